// File: rtl/usb_tx_encode.sv
// USB transmit serializer: SYNC, LSB-first NRZI data with bit stuffing, EOP.
// A one-byte holding register decouples the byte handshake from the line timing.
`timescale 1ns/1ps
module usb_tx_encode #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic       d_plus,
  output logic       d_minus
);

  // state   | meaning
  // IDLE    | line J, waiting for first byte
  // SYNC    | shifting out the fixed SYNC byte
  // DATA    | shifting out packet bytes
  // EOP_SE0 | two bit periods of SE0
  // EOP_J   | one bit period of J, then IDLE
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] EOP_SE0 = 3'd3;
  localparam logic [2:0] EOP_J   = 3'd4;

  localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [7:0]    SYNC_BYTE = 8'h80;

  logic [2:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          last_acc_q, last_acc_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    ones_q, ones_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          err_q, err_d;

  logic          hs;
  logic          bit_end;
  logic          send_bit;
  logic          nxt_bit;

  assign tx_ready = ~hold_full_q & ~last_acc_q &
                    (state_q != EOP_SE0) & (state_q != EOP_J);
  assign hs       = tx_valid & tx_ready;
  assign bit_end  = (cyc_q == '0);

  assign tx_busy  = (state_q != IDLE);
  assign tx_err   = err_q;
  assign d_plus   = dp_q;
  assign d_minus  = dm_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_acc_d  = last_acc_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    cyc_d       = cyc_q;
    ones_d      = ones_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    err_d       = 1'b0;
    send_bit    = 1'b0;
    nxt_bit     = 1'b0;

    if (hs) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      if (tx_last) begin
        last_acc_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = SYNC;
          shift_d   = {1'b0, SYNC_BYTE[7:1]};
          bit_idx_d = '0;
          cyc_d     = CYC_LOAD;
          send_bit  = 1'b1;
          nxt_bit   = SYNC_BYTE[0];
        end
      end

      SYNC, DATA: begin
        if (!bit_end) begin
          cyc_d = cyc_q - CYC_ONE;
        end else begin
          cyc_d = CYC_LOAD;
          if (ones_q == 3'd6) begin
            // stuff bit: forced toggle, byte position unchanged
            dp_d   = ~dp_q;
            dm_d   = ~dm_q;
            ones_d = '0;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            send_bit  = 1'b1;
            nxt_bit   = shift_q[0];
          end else if (hold_full_q || hs) begin
            // a byte arriving on the boundary cycle is used directly
            shift_d     = hold_full_q ? {1'b0, hold_q[7:1]} : {1'b0, tx_data[7:1]};
            nxt_bit     = hold_full_q ? hold_q[0] : tx_data[0];
            hold_full_d = 1'b0;
            state_d     = DATA;
            bit_idx_d   = '0;
            send_bit    = 1'b1;
          end else begin
            state_d   = EOP_SE0;
            err_d     = ~last_acc_q;
            bit_idx_d = '0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
          end
        end
      end

      EOP_SE0: begin
        if (!bit_end) begin
          cyc_d = cyc_q - CYC_ONE;
        end else begin
          cyc_d = CYC_LOAD;
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            state_d   = EOP_J;
            bit_idx_d = '0;
            dp_d      = 1'b1;
            dm_d      = 1'b0;
          end
        end
      end

      EOP_J: begin
        if (!bit_end) begin
          cyc_d = cyc_q - CYC_ONE;
        end else begin
          state_d     = IDLE;
          cyc_d       = '0;
          ones_d      = '0;
          last_acc_d  = 1'b0;
          hold_full_d = 1'b0;
          dp_d        = 1'b1;
          dm_d        = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // NRZI: a zero toggles the line, a one holds it and extends the run
    if (send_bit) begin
      if (nxt_bit) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = '0;
        dp_d   = ~dp_q;
        dm_d   = ~dm_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_acc_q  <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      cyc_q       <= '0;
      ones_q      <= '0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_acc_q  <= last_acc_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      cyc_q       <= cyc_d;
      ones_q      <= ones_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      err_q       <= err_d;
    end
  end

endmodule
